// File: rtl/mpath_arb.sv
// Multi-channel path arbiter: per-channel circular FIFOs with empty-FIFO bypass,
// merged onto one output by a round-robin arbiter (fixed priority when MPATH_ARB_PRIO_EN is defined).
module mpath_arb #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int NCH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH*DWIDTH-1:0]    data_i,
  input  logic [NCH-1:0]           valid_i,
  input  logic                     enable_i,
  input  logic [NCH-1:0]           flush_i,
  input  logic                     gnt_i,
  output logic                     req_o,
  output logic [DWIDTH-1:0]        data_o,
  output logic [$clog2(NCH)-1:0]   ch_o,
  output logic [NCH-1:0]           stall_o,
  output logic [NCH-1:0]           overflow_o,
  output logic                     underflow_o
);

  localparam int CWIDTH = $clog2(NCH);
  localparam int PW     = $clog2(DEPTH);
  localparam int NW     = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem_q    [NCH][DEPTH];
  logic [DWIDTH-1:0] mem_d    [NCH][DEPTH];
  logic [PW-1:0]     wr_ptr_q [NCH];
  logic [PW-1:0]     wr_ptr_d [NCH];
  logic [PW-1:0]     rd_ptr_q [NCH];
  logic [PW-1:0]     rd_ptr_d [NCH];
  logic [NW-1:0]     cnt_q    [NCH];
  logic [NW-1:0]     cnt_d    [NCH];

  logic [NCH-1:0]    empty, full, cand, pop, bypass, push, hit;
  logic [CWIDTH-1:0] sel;
  logic              grant;

`ifndef MPATH_ARB_PRIO_EN
  logic [CWIDTH-1:0] rr_q, rr_d;
`endif

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      empty[c] = (cnt_q[c] == '0);
      full[c]  = (cnt_q[c] == NW'(DEPTH));
      cand[c]  = !flush_i[c] && (!empty[c] || (valid_i[c] && enable_i));
    end
  end

  // First candidate found scanning upward from the search origin, wrapping at NCH.
  always_comb begin : arb
    int                idx_i;
    logic              found;
    logic [CWIDTH-1:0] idx;
    sel   = '0;
    found = 1'b0;
    idx_i = 0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef MPATH_ARB_PRIO_EN
      idx_i = i;
`else
      idx_i = int'(rr_q) + i;
      if (idx_i >= NCH) idx_i = idx_i - NCH;
`endif
      idx = CWIDTH'(idx_i);
      if (!found && cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_o       = |cand;
    grant       = gnt_i && req_o;
    ch_o        = req_o ? sel : '0;
    underflow_o = gnt_i && !req_o;
    data_o      = '0;
    if (req_o) begin
      data_o = empty[sel] ? data_i[int'(sel)*DWIDTH +: DWIDTH] : mem_q[sel][rd_ptr_q[sel]];
    end
    for (int c = 0; c < NCH; c++) begin
      hit[c]        = grant && (sel == CWIDTH'(c));
      pop[c]        = hit[c] && !empty[c];
      bypass[c]     = hit[c] && empty[c];
      push[c]       = valid_i[c] && enable_i && !flush_i[c] && !bypass[c] && (!full[c] || pop[c]);
      stall_o[c]    = !enable_i || (full[c] && !hit[c]);
      overflow_o[c] = valid_i[c] && enable_i && !flush_i[c] && full[c] && !pop[c];
    end
  end

  // Flush dominates; a flushed channel never wins arbitration, so pop is already 0 there.
  always_comb begin
    mem_d = mem_q;
    for (int c = 0; c < NCH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
      if (flush_i[c]) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end else begin
        if (push[c]) begin
          mem_d[c][wr_ptr_q[c]] = data_i[c*DWIDTH +: DWIDTH];
          wr_ptr_d[c]           = nxt_ptr(wr_ptr_q[c]);
        end
        if (pop[c]) rd_ptr_d[c] = nxt_ptr(rd_ptr_q[c]);
        if (push[c] && !pop[c]) cnt_d[c] = cnt_q[c] + 1'b1;
        else if (pop[c] && !push[c]) cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

`ifndef MPATH_ARB_PRIO_EN
  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (sel == CWIDTH'(NCH - 1)) ? '0 : sel + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
`ifndef MPATH_ARB_PRIO_EN
      rr_q <= '0;
`endif
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
`ifndef MPATH_ARB_PRIO_EN
      rr_q <= rr_d;
`endif
    end
  end

  // Storage carries no reset: validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
